// File: rtl/pipeline_stall_ctrl_if.sv
// Port bundle between the hazard unit / fetch side and the front-end pipeline
// register block. Signal names match the block's external interface.
interface pipeline_stall_ctrl_if #(
  parameter int CTRL_W = 9,
  parameter int CNT_W  = 16
);
  logic              pc_write;
  logic              if_id_write;
  logic              mux_sel;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic [31:0]       instr_in;
  logic [CTRL_W-1:0] ctrl_in;

  logic [31:0]       pc;
  logic [31:0]       if_id_pc4;
  logic [31:0]       if_id_instr;
  logic              if_id_valid;
  logic [CTRL_W-1:0] id_ex_ctrl;
  logic [CNT_W-1:0]  stall_count;
  logic [CNT_W-1:0]  flush_count;

  modport master (
    output pc_write, if_id_write, mux_sel, redirect_valid, redirect_pc,
           instr_in, ctrl_in,
    input  pc, if_id_pc4, if_id_instr, if_id_valid, id_ex_ctrl,
           stall_count, flush_count
  );

  modport slave (
    input  pc_write, if_id_write, mux_sel, redirect_valid, redirect_pc,
           instr_in, ctrl_in,
    output pc, if_id_pc4, if_id_instr, if_id_valid, id_ex_ctrl,
           stall_count, flush_count
  );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Front-end pipeline registers (PC, IF/ID, ID/EX control) under load-use stall
// and ID-stage redirect control, with saturating stall/flush event counters.
module pipeline_stall_ctrl #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          CTRL_W   = 9,
  parameter int          CNT_W    = 16
) (
  input logic                  clk,
  input logic                  reset,
  pipeline_stall_ctrl_if.slave bus
);

  logic [31:0]       pc_q,          pc_d;
  logic [31:0]       if_id_pc4_q,   if_id_pc4_d;
  logic [31:0]       if_id_instr_q, if_id_instr_d;
  logic              if_id_valid_q, if_id_valid_d;
  logic [CTRL_W-1:0] id_ex_ctrl_q,  id_ex_ctrl_d;
  logic [CNT_W-1:0]  stall_cnt_q,   stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q,   flush_cnt_d;

  logic        redirect_ok;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_target;

  // A stall outranks a redirect: ID operands are stale while stalled, so the
  // redirect is dropped and the ID stage re-asserts it after the stall.
  assign redirect_ok     = bus.redirect_valid & bus.pc_write;
  assign pc_plus4        = pc_q + 32'd4;
  assign redirect_target = bus.redirect_pc & ~32'h3;

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it
    // unassigned; a missing default here would infer a latch.
    pc_d          = pc_q;
    if_id_pc4_d   = if_id_pc4_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;
    id_ex_ctrl_d  = bus.ctrl_in;
    stall_cnt_d   = stall_cnt_q;
    flush_cnt_d   = flush_cnt_q;

    if (bus.pc_write) begin
      pc_d = redirect_ok ? redirect_target : pc_plus4;
    end

    // IF/ID write enable is independent of pc_write; with the PC held this
    // simply reloads the same fetch.
    if (bus.if_id_write) begin
      if (redirect_ok) begin
        if_id_instr_d = 32'h0;
        if_id_pc4_d   = 32'h0;
        if_id_valid_d = 1'b0;
      end else begin
        if_id_instr_d = bus.instr_in;
        if_id_pc4_d   = pc_plus4;
        if_id_valid_d = 1'b1;
      end
    end

    if (bus.mux_sel || !if_id_valid_q) begin
      id_ex_ctrl_d = '0;
    end

    if (!bus.pc_write && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (redirect_ok && !(&flush_cnt_q)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignment so every register
  // samples the pre-edge value of the others, regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= PC_RESET;
      if_id_pc4_q   <= 32'h0;
      if_id_instr_q <= 32'h0;
      if_id_valid_q <= 1'b0;
      id_ex_ctrl_q  <= '0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      pc_q          <= pc_d;
      if_id_pc4_q   <= if_id_pc4_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
      id_ex_ctrl_q  <= id_ex_ctrl_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.if_id_pc4   = if_id_pc4_q;
  assign bus.if_id_instr = if_id_instr_q;
  assign bus.if_id_valid = if_id_valid_q;
  assign bus.id_ex_ctrl  = id_ex_ctrl_q;
  assign bus.stall_count = stall_cnt_q;
  assign bus.flush_count = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench: directed test-plan scenarios plus randomized hazards,
// checked against a cycle-level behavioural model of the front end.
module tb_pipeline_stall_ctrl;

  localparam int CTRL_W = 9;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  pipeline_stall_ctrl_if #(.CTRL_W(CTRL_W), .CNT_W(16)) ifa ();
  pipeline_stall_ctrl_if #(.CTRL_W(CTRL_W), .CNT_W(2))  ifb ();

  pipeline_stall_ctrl #(.PC_RESET(32'h0), .CTRL_W(CTRL_W), .CNT_W(16)) dut_a (
    .clk(clk), .reset(rst_a), .bus(ifa.slave)
  );
  pipeline_stall_ctrl #(.PC_RESET(32'hFFFF_FFFC), .CTRL_W(CTRL_W), .CNT_W(2)) dut_b (
    .clk(clk), .reset(rst_b), .bus(ifb.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural model of DUT A, in plain integer arithmetic.
  longint m_pc, m_pc4, m_instr, m_ctrl, m_stall, m_flush;
  bit     m_valid;
  localparam longint CNT_MAX_A = 65535;
  localparam longint MOD32     = 64'h1_0000_0000;

  function automatic longint min_l(input longint a, input longint b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    m_pc = 0; m_pc4 = 0; m_instr = 0; m_valid = 0;
    m_ctrl = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic model_step();
    bit taken;
    longint next_pc;
    taken = ifa.redirect_valid && ifa.pc_write;
    next_pc = (m_pc + 4) % MOD32;
    m_ctrl = (ifa.mux_sel || !m_valid) ? 0 : longint'(ifa.ctrl_in);
    if (ifa.if_id_write) begin
      if (taken) begin
        m_instr = 0; m_pc4 = 0; m_valid = 0;
      end else begin
        m_instr = longint'(ifa.instr_in); m_pc4 = next_pc; m_valid = 1;
      end
    end
    if (ifa.pc_write)
      m_pc = taken ? (longint'(ifa.redirect_pc) / 4) * 4 : next_pc;
    if (!ifa.pc_write) m_stall = min_l(m_stall + 1, CNT_MAX_A);
    if (taken)         m_flush = min_l(m_flush + 1, CNT_MAX_A);
  endtask

  task automatic compare_a(input string phase);
    check({phase, ".pc"},    ifa.pc,          m_pc);
    check({phase, ".pc4"},   ifa.if_id_pc4,   m_pc4);
    check({phase, ".instr"}, ifa.if_id_instr, m_instr);
    check({phase, ".valid"}, ifa.if_id_valid, m_valid);
    check({phase, ".ctrl"},  ifa.id_ex_ctrl,  m_ctrl);
    check({phase, ".stall"}, ifa.stall_count, m_stall);
    check({phase, ".flush"}, ifa.flush_count, m_flush);
  endtask

  // One edge of DUT A: inputs already driven, model steps at the edge,
  // outputs compared on the following falling edge.
  task automatic cycle_a(input string phase);
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_a(phase);
  endtask

  task automatic drive_a(input bit pw, input bit iw, input bit ms, input bit rv,
                         input logic [31:0] rpc, input logic [31:0] instr);
    ifa.pc_write       = pw;
    ifa.if_id_write    = iw;
    ifa.mux_sel        = ms;
    ifa.redirect_valid = rv;
    ifa.redirect_pc    = rpc;
    ifa.instr_in       = instr;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    drive_a(1, 1, 0, 0, 32'h0, 32'h0);
    ifa.ctrl_in = 9'h1A5;
    ifb.pc_write = 1'b1; ifb.if_id_write = 1'b1; ifb.mux_sel = 1'b0;
    ifb.redirect_valid = 1'b0; ifb.redirect_pc = 32'h0;
    ifb.instr_in = 32'h0; ifb.ctrl_in = '0;
    model_reset();

    @(negedge clk);
    @(negedge clk);
    compare_a("reset");
    rst_a = 1'b0;

    // Sequential fetch
    drive_a(1, 1, 0, 0, 32'h0, 32'h11); cycle_a("fetch0");
    check("fetch0.pc_const", ifa.pc, 32'h4);
    drive_a(1, 1, 0, 0, 32'h0, 32'h22); cycle_a("fetch1");
    check("fetch1.instr_const", ifa.if_id_instr, 32'h22);
    check("fetch1.pc4_const", ifa.if_id_pc4, 32'h8);

    // Load-use stall at pc=0x8
    drive_a(0, 0, 1, 0, 32'h0, 32'h33); cycle_a("stall");
    check("stall.pc_const", ifa.pc, 32'h8);
    check("stall.ctrl_const", ifa.id_ex_ctrl, 9'h0);
    check("stall.cnt_const", ifa.stall_count, 16'd1);
    drive_a(1, 1, 0, 0, 32'h0, 32'h33); cycle_a("unstall");
    check("unstall.pc_const", ifa.pc, 32'hC);
    drive_a(1, 1, 0, 0, 32'h0, 32'h44); cycle_a("fetch3");

    // Redirect at pc=0x10 to unaligned 0x103
    drive_a(1, 1, 0, 1, 32'h103, 32'h55); cycle_a("redir");
    check("redir.pc_const", ifa.pc, 32'h100);
    check("redir.valid_const", ifa.if_id_valid, 1'b0);
    check("redir.flush_const", ifa.flush_count, 16'd1);
    drive_a(1, 1, 0, 0, 32'h0, 32'h66); cycle_a("postredir");
    check("postredir.ctrl_const", ifa.id_ex_ctrl, 9'h0);
    check("postredir.instr_const", ifa.if_id_instr, 32'h66);

    // Stall and redirect in the same cycle: redirect dropped
    drive_a(0, 0, 1, 1, 32'h200, 32'h77); cycle_a("stallredir");
    check("stallredir.pc_const", ifa.pc, 32'h104);
    check("stallredir.flush_const", ifa.flush_count, 16'd1);
    check("stallredir.stall_const", ifa.stall_count, 16'd2);

    // Get to pc=0x40, then reset between edges
    drive_a(1, 1, 0, 1, 32'h40, 32'h88); cycle_a("to40");
    drive_a(1, 1, 0, 0, 32'h0, 32'h99);
    #2 rst_a = 1'b1;
    #1;
    model_reset();
    compare_a("midreset");
    #1 rst_a = 1'b0;
    cycle_a("afterreset");
    check("afterreset.pc_const", ifa.pc, 32'h4);

    // Randomized hazards, redirects and data
    for (int i = 0; i < 400; i++) begin
      drive_a($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
              $urandom, $urandom);
      ifa.ctrl_in = CTRL_W'($urandom);
      cycle_a("rand");
    end

    // DUT B: PC wrap from 0xFFFFFFFC and 2-bit counter saturation
    rst_b = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("wrap.pc", ifb.pc, 32'h0);
    check("wrap.pc4", ifb.if_id_pc4, 32'h0);
    ifb.pc_write = 1'b0; ifb.if_id_write = 1'b0; ifb.mux_sel = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("sat.stall", ifb.stall_count, (k < 3) ? k : 3);
      check("sat.pc", ifb.pc, 32'h0);
    end
    check("sat.flush", ifb.flush_count, 2'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Front-end pipeline register block that acts on the load-use hazard unit's `pc_write`, `if_id_write` and `mux_sel` outputs. It holds the PC, the IF/ID register and the ID/EX control bundle, and it squashes the fetched instruction on an ID-stage branch or jump redirect. It also keeps saturating stall and flush event counters for performance debug. It sits between instruction memory/control unit and the ID/EX datapath register of the 5-stage MIPS pipeline.

## Interface
- `PC_RESET`, default 32'h0000_0000, PC value after reset.
- `CTRL_W`, default 9, width of the ID/EX control bundle.
- `CNT_W`, default 16, width of each event counter.

- `clk`  in  1  pipeline clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `pc_write`  in  1  1 = PC may update; 0 = hold PC.
- `if_id_write`  in  1  1 = IF/ID may update; 0 = hold IF/ID.
- `mux_sel`  in  1  1 = insert a bubble (zero control) into ID/EX.
- `redirect_valid`  in  1  branch taken or jump, resolved in ID.
- `redirect_pc`  in  32  redirect target.
- `instr_in`  in  32  instruction memory data at current `pc`.
- `ctrl_in`  in  CTRL_W  control unit output for the instruction in IF/ID.
- `pc`  out  32  current fetch address.
- `if_id_pc4`  out  32  registered PC+4 of the fetched instruction.
- `if_id_instr`  out  32  registered instruction.
- `if_id_valid`  out  1  0 = IF/ID holds a squashed slot.
- `id_ex_ctrl`  out  CTRL_W  registered control bundle for EX.
- `stall_count`  out  CNT_W  cycles with `pc_write`=0.
- `flush_count`  out  CNT_W  redirects that were honored.

## Operation
- **Reset (async, immediate):**
  - `pc`=PC_RESET.
  - `if_id_pc4`=0, `if_id_instr`=0 (nop), `if_id_valid`=0.
  - `id_ex_ctrl`=0.
  - Both counters = 0.
- **Redirect honoring:** define redirect_ok = `redirect_valid` & `pc_write`. A stall takes priority over a redirect, because ID operands are stale during a load-use stall. A redirect seen during a stall is dropped. The ID stage re-asserts it once the stall clears.
- **PC update, per edge, in priority order:**
  1. If `pc_write`=0: hold.
  2. Else if redirect_ok: `pc` = {redirect_pc[31:2], 2'b00}.
  3. Else: `pc` = pc+4, modulo 2^32 (0xFFFFFFFC wraps to 0).
- **IF/ID update, per edge, in priority order:**
  1. If `if_id_write`=0: hold all three fields.
  2. Else if redirect_ok: load instr=0, pc4=0, valid=0 (flush).
  3. Else: load `instr_in`, pc+4, valid=1.
- **ID/EX control:** updates every edge and never stalls.
  - If `mux_sel`=1 or `if_id_valid`=0: load all-zero (bubble).
  - Else: load `ctrl_in`.
- **Counters:** both saturate at all-ones; no wrap.
  - `stall_count` +1 on each edge where `pc_write`=0.
  - `flush_count` +1 on each edge where redirect_ok=1.
- **Independent write enables:** `pc_write` and `if_id_write` are obeyed independently. No interlock is applied. With `pc_write`=0 and `if_id_write`=1, IF/ID reloads the same `instr_in`. This behaviour is defined; it is not an error.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Latency is one edge from any input to the affected output.
- A hazard asserted for N cycles freezes PC and IF/ID for exactly N edges. During those edges ID/EX receives N bubbles.
- Redirect costs exactly one squashed slot:
  - Edge k: redirect honored, IF/ID flushed.
  - Edge k+1: `id_ex_ctrl`=0.
  - Edge k+1: IF/ID holds the target instruction.
- Reset asserted mid-operation clears all state immediately, regardless of clock. The first fetch after deassertion is from PC_RESET.

## Test plan
- **Sequential fetch:** reset release, `instr_in`=0x11,0x22,0x33, no hazards.
  - `pc` = 0x0 → 0x4 → 0x8 → 0xC.
  - `if_id_instr` = 0x11,0x22,0x33 with `if_id_pc4` = 0x4,0x8,0xC.
  - `if_id_valid`=1.
- **Load-use stall:** at `pc`=0x8, drive `pc_write`=0, `if_id_write`=0, `mux_sel`=1 for one cycle.
  - `pc` stays 0x8; IF/ID unchanged.
  - `id_ex_ctrl`=0; `stall_count`=1.
  - Next edge: `pc`=0xC.
- **Redirect:** `redirect_valid`=1, `redirect_pc`=0x103 at `pc`=0x10.
  - `pc`=0x100; `if_id_valid`=0; `if_id_instr`=0; `flush_count`=1.
  - Following edge: `id_ex_ctrl`=0.
- **Stall plus redirect in the same cycle:**
  - `pc` held; IF/ID held; `flush_count` unchanged; `stall_count` +1.
- **Reset mid-run:** assert `reset` between edges with `pc`=0x40 and counters nonzero.
  - All outputs go to reset values before the next edge.
- **Wrap and saturation:** use PC_RESET=0xFFFFFFFC and CNT_W=2.
  - First edge: `pc`=0x0.
  - 5 consecutive stall cycles: `stall_count`=3 and holds.
